addsub_16bit_seq: RTL and testbench

Multi-cycle 16-bit two's-complement adder/subtractor for the ALU datapath. It processes one 4-bit slice per clock, LSB slice first, and keeps a registered carry between slices. Operands are latched on a start/done handshake. It produces a registered Sum plus Ovfl, Zero, Neg and Cout flags for downstream flag-register logic.

---
 rtl/addsub_16bit_seq_if.sv | 27 ++
 rtl/addsub_16bit_seq.sv | 121 ++++++++++++
 tb/tb_addsub_16bit_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/addsub_16bit_seq_if.sv
// Operand/result bundle of the sequential adder/subtractor.
// The master drives the request side; the slave (the datapath) drives results and status.
interface addsub_16bit_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Ovfl;
    logic             Zero;
    logic             Neg;
    logic             Cout;

    modport master (
        output start, A, B, sub,
        input  busy, done, Sum, Ovfl, Zero, Neg, Cout
    );

    modport slave (
        input  start, A, B, sub,
        output busy, done, Sum, Ovfl, Zero, Neg, Cout
    );
endinterface

// File: rtl/addsub_16bit_seq.sv
// Multi-cycle two's-complement adder/subtractor: one SLICE-bit ripple step per clock,
// LSB slice first, with a registered carry between slices and registered result flags.
module addsub_16bit_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    addsub_16bit_seq_if.slave     bus
);
    localparam int NSL = WIDTH / SLICE;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] sum_q;
    logic             ovfl_q;
    logic             zero_q;
    logic             neg_q;
    logic             cout_q;

    logic             last;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   slice_sum;
    logic             c_into_msb;
    logic [WIDTH-1:0] acc_nx;

    assign last = (k == KW'(NSL - 1));

    // One slice of the ripple adder plus the accumulator image after this step.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        a_sl      = op_a[k*SLICE +: SLICE];
        b_sl      = op_b[k*SLICE +: SLICE];
        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE + 1)'(carry);
        acc_nx    = acc;
        acc_nx[k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    end

    // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ cin.
    assign c_into_msb = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ slice_sum[SLICE-1];

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is assigned with <= so all registers update from pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand and accumulator regs are reset too, so an aborted operation leaves nothing behind.
            k      <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            sum_q  <= '0;
            ovfl_q <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtract as A + ~B + 1; the +1 rides in on the initial carry.
                        op_a  <= bus.A;
                        op_b  <= bus.sub ? ~bus.B : bus.B;
                        carry <= bus.sub;
                        k     <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nx;
                    carry <= slice_sum[SLICE];
                    k     <= k + 1'b1;
                    if (last) begin
                        sum_q  <= acc_nx;
                        cout_q <= slice_sum[SLICE];
                        ovfl_q <= c_into_msb ^ slice_sum[SLICE];
                        zero_q <= (acc_nx == '0);
                        neg_q  <= acc_nx[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.Sum  = sum_q;
    assign bus.Ovfl = ovfl_q;
    assign bus.Zero = zero_q;
    assign bus.Neg  = neg_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_addsub_16bit_seq.sv
// Scoreboard bench for addsub_16bit_seq: the driver queues expected results,
// an independent monitor pops and compares on every done pulse.
module tb_addsub_16bit_seq;
    typedef struct packed {
        logic [15:0] sum;
        logic        ovfl;
        logic        zero;
        logic        neg;
        logic        cout;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   done_count;
    exp_t exp_q[$];

    addsub_16bit_seq_if #(.WIDTH(16)) bus ();

    addsub_16bit_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic o, input logic z,
                                input logic n, input logic c);
        exp_t e;
        e.sum = s; e.ovfl = o; e.zero = z; e.neg = n; e.cout = c;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum",  32'(bus.Sum),  32'(e.sum));
                check("ovfl", 32'(bus.Ovfl), 32'(e.ovfl));
                check("zero", 32'(bus.Zero), 32'(e.zero));
                check("neg",  32'(bus.Neg),  32'(e.neg));
                check("cout", 32'(bus.Cout), 32'(e.cout));
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_sum"},  32'(bus.Sum),  32'd0);
        check({tag, "_ovfl"}, 32'(bus.Ovfl), 32'd0);
        check({tag, "_zero"}, 32'(bus.Zero), 32'd0);
        check({tag, "_neg"},  32'(bus.Neg),  32'd0);
        check({tag, "_cout"}, 32'(bus.Cout), 32'd0);
    endtask

    // Issue one operation; edges are counted from the start edge inclusive.
    // With poke set, start is re-pulsed with junk operands during RUN and during DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input exp_t e, input bit poke);
        int  edges;
        int  busy_cycles;
        bit  seen;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.sub = s; bus.start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = ~a; bus.B = ~b; bus.sub = ~s;
        edges = 0; busy_cycles = 0; seen = 1'b0;
        while (!seen && edges < 20) begin
            @(negedge clk);
            edges++;
            if (bus.busy) busy_cycles++;
            if (bus.done) seen = 1'b1;
            if (poke && edges == 2) begin bus.start = 1'b1; bus.A = 16'hAAAA; end
            if (poke && edges == 3) bus.start = 1'b0;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_latency_edges", 32'(edges), 32'd5);
        if (poke) begin bus.start = 1'b1; bus.A = 16'hAAAA; bus.B = 16'h5555; end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_cycles", 32'(busy_cycles), 32'd5);
        check("busy_after", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int dc;
        int guard;
        n_checks = 0; n_fail = 0; done_count = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.sub = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        run_op(16'h1234, 16'h0FFF, 1'b0, mk(16'h2233, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
        run_op(16'h0000, 16'h8000, 1'b1, mk(16'h8000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0);

        // Ignored start pulses while busy must not queue a second operation.
        run_op(16'h0001, 16'h0001, 1'b0, mk(16'h0002, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        dc = done_count;
        repeat (8) @(negedge clk);
        check("protect_no_extra_done", 32'(done_count), 32'(dc));
        check("protect_idle", 32'(bus.busy), 32'd0);

        // Reset in the third RUN cycle aborts the operation immediately.
        @(negedge clk);
        bus.A = 16'h1111; bus.B = 16'h2222; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        dc = done_count;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'(dc));

        run_op(16'h0003, 16'h0001, 1'b1, mk(16'h0002, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("total_done_pulses", 32'(done_count), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
